jt7759_romrd: RTL and testbench

JT7759_ROMRD -- requirements
Module: jt7759_romrd

---
 rtl/jt7759_pkg.sv | 13 +
 rtl/jt7759_romrd_line.sv | 33 +++
 rtl/jt7759_romrd.sv | 129 ++++++++++++
 tb/tb_jt7759_romrd.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_pkg.sv
// Shared widths and FSM encoding for the jt7759 ROM read cache.
package jt7759_pkg;
  localparam int BAW = 17;
  localparam int WAW = 16;
  localparam int DW  = 16;
  localparam int TW  = WAW - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEMAND,
    ST_PREF
  } state_t;
endpackage

// File: rtl/jt7759_romrd_line.sv
// One cache line: tag, valid bit and 16-bit word.
module jt7759_romrd_line
  import jt7759_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          flush,
  input  logic [TW-1:0] wtag,
  input  logic [DW-1:0] wdata,
  output logic          valid,
  output logic [TW-1:0] tag,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (we)
        valid <= 1'b1;
      if (we) begin
        tag  <= wtag;
        data <= wdata;
      end
    end
  end

endmodule

// File: rtl/jt7759_romrd.sv
// Two-line word cache between the ADPCM byte reader and a 16-bit ROM,
// with optional next-word prefetch.
module jt7759_romrd
  import jt7759_pkg::*;
#(
  parameter bit PREFETCH = 1'b1
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           rom_cs,
  input  logic [BAW-1:0] rom_addr,
  output logic [7:0]     rom_data,
  output logic           rom_ok,
  input  logic           flush,
  output logic           mem_cs,
  output logic [WAW-1:0] mem_addr,
  input  logic [DW-1:0]  mem_data,
  input  logic           mem_ok
);

  state_t         state, state_nx;
  logic           cs_nx;
  logic [WAW-1:0] addr_nx;
  logic           discard, discard_nx;

  logic [1:0]     valid;
  logic [TW-1:0]  tag [2];
  logic [DW-1:0]  data [2];
  logic [1:0]     we;

  logic           idx;
  logic           hit;
  logic [DW-1:0]  sel;
  logic           fill;
  logic           keep;
  logic [WAW-1:0] nxt_word;
  logic           other;
  logic           have_next;

  for (genvar i = 0; i < 2; i++) begin : g_line
    jt7759_romrd_line u_line (
      .clk   (clk),
      .rst   (rst),
      .we    (we[i]),
      .flush (flush),
      .wtag  (mem_addr[WAW-1:1]),
      .wdata (mem_data),
      .valid (valid[i]),
      .tag   (tag[i]),
      .data  (data[i])
    );
  end

  assign idx = rom_addr[1];
  assign hit = rom_cs & valid[idx]
             & (tag[idx] == rom_addr[BAW-1:2]);
  assign rom_ok = hit;
  assign sel = data[idx];
  assign rom_data = rom_addr[0] ? sel[15:8] : sel[7:0];

  // A flush seen at or after issue poisons the fill.
  assign fill = (state != ST_IDLE) & mem_cs & mem_ok;
  assign keep = fill & ~discard & ~flush;
  assign we   = keep ? (mem_addr[0] ? 2'b10 : 2'b01) : 2'b00;

  assign nxt_word  = mem_addr + 16'd1;
  assign other     = ~mem_addr[0];
  assign have_next = valid[other]
                   & (tag[other] == nxt_word[WAW-1:1]);

  always_comb begin
    state_nx   = state;
    cs_nx      = mem_cs;
    addr_nx    = mem_addr;
    discard_nx = discard | (flush & (state != ST_IDLE));
    unique case (state)
      ST_IDLE: begin
        discard_nx = 1'b0;
        if (rom_cs & ~hit) begin
          state_nx = ST_DEMAND;
          cs_nx    = 1'b1;
          addr_nx  = rom_addr[BAW-1:1];
        end
      end
      ST_DEMAND: begin
        if (mem_ok) begin
          cs_nx = 1'b0;
          if (PREFETCH && keep && !have_next)
            state_nx = ST_PREF;
          else
            state_nx = ST_IDLE;
        end
      end
      ST_PREF: begin
        // First PREF cycle keeps mem_cs low as the bus gap.
        if (!mem_cs) begin
          if (flush) begin
            state_nx = ST_IDLE;
          end else begin
            cs_nx   = 1'b1;
            addr_nx = nxt_word;
          end
        end else if (mem_ok) begin
          cs_nx    = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cs_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      mem_cs   <= cs_nx;
      mem_addr <= addr_nx;
      discard  <= discard_nx;
    end
  end

endmodule

// File: tb/tb_jt7759_romrd.sv
// Directed bench for jt7759_romrd with a fixed-latency memory model.
module tb_jt7759_romrd;

  logic        rst;
  logic        clk;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        flush;
  logic        mem_cs;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ok;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int last_mok = 0;
  int rok_rise = 0;
  bit cs_prev = 0;
  bit rok_prev = 0;
  int lat = 0;
  bit auto_mem = 1;
  bit manual_ok = 0;
  logic [15:0] req_addr [$];
  int          req_gap [$];

  jt7759_romrd #(.PREFETCH(1'b1)) dut (
    .rst      (rst),
    .clk      (clk),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .flush    (flush),
    .mem_cs   (mem_cs),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ok   (mem_ok)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    if (a == 16'h0008) return 16'hA55A;
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  // Memory responder and request logger, sampling 1 unit after each edge.
  initial begin
    mem_ok = 0;
    mem_data = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_cs && !cs_prev) begin
        req_addr.push_back(mem_addr);
        req_gap.push_back(cyc - last_mok);
      end
      cs_prev = mem_cs;
      if (rom_ok && !rok_prev) rok_rise = cyc;
      rok_prev = rom_ok;
      if (auto_mem) begin
        if (mem_ok) begin
          mem_ok = 0;
          lat = 0;
        end else if (mem_cs) begin
          if (lat == 2) begin
            mem_ok = 1;
            mem_data = word(mem_addr);
            last_mok = cyc;
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end else begin
        mem_ok = manual_ok;
        mem_data = 16'hDEAD;
        lat = 0;
      end
    end
  end

  task automatic wait_ok(output bit got);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_ok) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_cs(output bit got);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_cs) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; rom_cs = 0; rom_addr = 0; flush = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_cs !== 1'b0) begin
      errors++; $display("FAIL rst_mem_cs got %b want 0", mem_cs);
    end
    checks++;
    if (mem_addr !== 16'h0000) begin
      errors++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr);
    end
    rom_cs = 1;
    #1;
    checks++;
    if (rom_ok !== 1'b0 || rom_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_rom got ok=%b data=%h want 0/00", rom_ok, rom_data);
    end
    rom_cs = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_miss_hit;
    int n0;
    bit got;
    n0 = req_addr.size();
    rom_cs = 1; rom_addr = 17'h00011;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++; $display("FAIL miss_comb got %b want 0", rom_ok);
    end
    wait_ok(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL miss_timeout got 0 want rom_ok");
    end
    checks++;
    if (rom_data !== 8'hA5) begin
      errors++; $display("FAIL miss_data got %h want a5", rom_data);
    end
    checks++;
    if (req_addr.size() != n0 + 1 || req_addr[n0] !== 16'h0008) begin
      errors++;
      $display("FAIL miss_req got n=%0d want one req at 0008", req_addr.size() - n0);
    end
    checks++;
    if (rok_rise - last_mok != 1) begin
      errors++; $display("FAIL fill_lat got %0d want 1", rok_rise - last_mok);
    end
    rom_addr = 17'h00010;
    #1;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 8'h5A) begin
      errors++;
      $display("FAIL hit_even got ok=%b data=%h want 1/5a", rom_ok, rom_data);
    end
    rom_cs = 0;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++; $display("FAIL cs_low got %b want 0", rom_ok);
    end
  endtask

  task automatic test_prefetch;
    int n0;
    n0 = req_addr.size() - 1;
    repeat (10) @(negedge clk);
    checks++;
    if (req_addr.size() != n0 + 2) begin
      errors++; $display("FAIL pref_cnt got %0d want 2", req_addr.size() - n0);
    end else begin
      checks++;
      if (req_addr[n0+1] !== 16'h0009 || req_gap[n0+1] != 2) begin
        errors++;
        $display("FAIL pref_req got %h gap %0d want 0009 gap 2",
                 req_addr[n0+1], req_gap[n0+1]);
      end
    end
    rom_cs = 1; rom_addr = 17'h00012;
    #1;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 8'h34) begin
      errors++;
      $display("FAIL pref_hit_lo got ok=%b data=%h want 1/34", rom_ok, rom_data);
    end
    @(negedge clk);
    rom_addr = 17'h00013;
    #1;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 8'h1B) begin
      errors++;
      $display("FAIL pref_hit_hi got ok=%b data=%h want 1/1b", rom_ok, rom_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_addr.size() != n0 + 2) begin
      errors++; $display("FAIL pref_traffic got %0d want 2", req_addr.size() - n0);
    end
    rom_cs = 0;
  endtask

  task automatic test_wrap;
    int n0;
    bit got;
    n0 = req_addr.size();
    rom_cs = 1; rom_addr = 17'h1FFFE;
    wait_ok(got);
    checks++;
    if (!got || rom_data !== 8'hCB) begin
      errors++; $display("FAIL wrap_dem got ok=%b data=%h want 1/cb", got, rom_data);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (req_addr.size() != n0 + 2) begin
      errors++; $display("FAIL wrap_cnt got %0d want 2", req_addr.size() - n0);
    end else begin
      checks++;
      if (req_addr[n0] !== 16'hFFFF || req_addr[n0+1] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_req got %h,%h want ffff,0000", req_addr[n0], req_addr[n0+1]);
      end
    end
    rom_addr = 17'h00000;
    #1;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 8'h34) begin
      errors++;
      $display("FAIL wrap_hit got ok=%b data=%h want 1/34", rom_ok, rom_data);
    end
    rom_cs = 0;
    @(negedge clk);
  endtask

  task automatic test_flush;
    int n0;
    bit got;
    n0 = req_addr.size();
    rom_cs = 1; rom_addr = 17'h00200;
    wait_cs(got);
    flush = 1;
    @(negedge clk);
    flush = 0;
    rom_addr = 17'h00000;
    #1;
    checks++;
    if (!got || rom_ok !== 1'b0) begin
      errors++; $display("FAIL flush_inv got ok=%b cs=%b want 0/1", rom_ok, got);
    end
    rom_addr = 17'h00200;
    wait_ok(got);
    checks++;
    if (!got || rom_data !== 8'h35) begin
      errors++; $display("FAIL flush_refill got ok=%b data=%h want 1/35", got, rom_data);
    end
    checks++;
    if (req_addr.size() != n0 + 2) begin
      errors++; $display("FAIL flush_early got %0d reqs want 2", req_addr.size() - n0);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (req_addr.size() != n0 + 3) begin
      errors++; $display("FAIL flush_cnt got %0d want 3", req_addr.size() - n0);
    end else begin
      checks++;
      if (req_addr[n0] !== 16'h0100 || req_addr[n0+1] !== 16'h0100 ||
          req_addr[n0+2] !== 16'h0101 || req_gap[n0+1] != 2) begin
        errors++;
        $display("FAIL flush_seq got %h,%h,%h gap %0d want 0100,0100,0101 gap 2",
                 req_addr[n0], req_addr[n0+1], req_addr[n0+2], req_gap[n0+1]);
      end
    end
    rom_cs = 0;
  endtask

  task automatic test_demand_during_pref;
    int n0;
    bit got;
    n0 = req_addr.size();
    rom_cs = 1; rom_addr = 17'h00400;
    wait_ok(got);
    wait_cs(got);
    rom_addr = 17'h00100;
    wait_ok(got);
    checks++;
    if (!got || rom_data !== 8'h34) begin
      errors++; $display("FAIL dpref_data got ok=%b data=%h want 1/34", got, rom_data);
    end
    checks++;
    if (req_addr.size() < n0 + 3) begin
      errors++; $display("FAIL dpref_cnt got %0d want 3", req_addr.size() - n0);
    end else begin
      checks++;
      if (req_addr[n0+1] !== 16'h0201 || req_addr[n0+2] !== 16'h0080 ||
          req_gap[n0+2] != 2) begin
        errors++;
        $display("FAIL dpref_seq got %h,%h gap %0d want 0201,0080 gap 2",
                 req_addr[n0+1], req_addr[n0+2], req_gap[n0+2]);
      end
    end
    repeat (10) @(negedge clk);
    rom_cs = 0;
  endtask

  task automatic test_cs_drop;
    int n0;
    bit got;
    n0 = req_addr.size();
    rom_cs = 1; rom_addr = 17'h01000;
    wait_cs(got);
    rom_cs = 0;
    repeat (12) @(negedge clk);
    rom_cs = 1;
    #1;
    checks++;
    if (!got || rom_ok !== 1'b1 || rom_data !== 8'h3C) begin
      errors++;
      $display("FAIL csdrop got ok=%b data=%h want 1/3c", rom_ok, rom_data);
    end
    checks++;
    if (req_addr.size() != n0 + 2 || req_addr[n0] !== 16'h0800) begin
      errors++; $display("FAIL csdrop_req got %0d reqs want 2", req_addr.size() - n0);
    end
    rom_cs = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got;
    auto_mem = 0;
    rom_cs = 1; rom_addr = 17'h00800;
    wait_cs(got);
    rst = 1;
    #1;
    checks++;
    if (!got || mem_cs !== 1'b0 || rom_ok !== 1'b0 || rom_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid got cs=%b ok=%b data=%h want 0/0/00", mem_cs, rom_ok, rom_data);
    end
    @(negedge clk);
    rst = 0;
    rom_cs = 0;
    manual_ok = 1;
    @(negedge clk);
    manual_ok = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_cs !== 1'b0) begin
      errors++; $display("FAIL rstmid_cs got %b want 0", mem_cs);
    end
    rom_cs = 1;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++; $display("FAIL rstmid_late_ok got %b want 0", rom_ok);
    end
    rom_addr = 17'h00100;
    #1;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++; $display("FAIL rstmid_old got %b want 0", rom_ok);
    end
    rom_cs = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_prefetch();
    test_wrap();
    test_flush();
    test_demand_during_pref();
    test_cs_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
